// File: rtl/core_stim_driver.sv
// Host-side initiator for the core's op/in/out protocol.
// Issues op codes from an op ROM, streams load bytes from a data ROM for mode-0 ops,
// and checks every core output beat against a golden ROM.
module core_stim_driver #(
  parameter int unsigned OP_NUM   = 41,
  parameter int unsigned LOAD_LEN = 2048,
  parameter int unsigned OP_AW    = 10,
  parameter int unsigned IN_AW    = 11,
  parameter int unsigned GD_AW    = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_op_valid,
  output logic [3:0]       o_op_mode,
  input  logic             i_op_ready,
  output logic             o_in_valid,
  output logic [7:0]       o_in_data,
  input  logic             i_in_ready,
  input  logic             i_out_valid,
  input  logic [13:0]      i_out_data,
  output logic [OP_AW-1:0] o_op_addr,
  input  logic [3:0]       i_op_rdata,
  output logic [IN_AW-1:0] o_in_addr,
  input  logic [7:0]       i_in_rdata,
  output logic [GD_AW-1:0] o_gd_addr,
  input  logic [13:0]      i_gd_rdata,
  output logic             o_done,
  output logic [15:0]      o_err_cnt,
  output logic [GD_AW-1:0] o_out_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StIssue,
    StLoad,
    StNext,
    StDone
  } state_e;

  localparam logic [OP_AW-1:0] OpLast = OP_AW'(OP_NUM - 1);
  localparam logic [IN_AW-1:0] LdLast = IN_AW'(LOAD_LEN - 1);

  state_e           state_q, state_d;
  logic             op_valid_q, op_valid_d;
  logic [3:0]       op_mode_q, op_mode_d;
  logic [OP_AW-1:0] op_idx_q, op_idx_d;
  logic [IN_AW-1:0] ld_idx_q, ld_idx_d;
  logic             in_valid_q, in_valid_d;
  logic             done_q, done_d;
  logic [GD_AW-1:0] out_cnt_q, out_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic in_accept;
  logic start_ok;

  assign in_accept = in_valid_q & i_in_ready;
  assign start_ok  = i_start & ((state_q == StIdle) | (state_q == StDone));

  // State register and all registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      op_valid_q <= 1'b0;
      op_mode_q  <= 4'd0;
      op_idx_q   <= '0;
      ld_idx_q   <= '0;
      in_valid_q <= 1'b0;
      done_q     <= 1'b0;
      out_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_valid_q <= op_valid_d;
      op_mode_q  <= op_mode_d;
      op_idx_q   <= op_idx_d;
      ld_idx_q   <= ld_idx_d;
      in_valid_q <= in_valid_d;
      done_q     <= done_d;
      out_cnt_q  <= out_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (i_start) state_d = StWaitRdy;
      StWaitRdy:      if (i_op_ready) state_d = StIssue;
      StIssue:        state_d = (op_mode_q == 4'd0) ? StLoad : StNext;
      StLoad:         if (in_accept && (ld_idx_q == LdLast)) state_d = StNext;
      StNext:         state_d = (op_idx_q == OpLast) ? StDone : StWaitRdy;
      default:        state_d = StIdle;
    endcase
  end

  // Output and datapath next values, including the output-beat checker
  always_comb begin
    op_valid_d = op_valid_q;
    op_mode_d  = op_mode_q;
    op_idx_d   = op_idx_q;
    ld_idx_d   = ld_idx_q;
    in_valid_d = in_valid_q;
    done_d     = done_q;
    out_cnt_d  = out_cnt_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      StWaitRdy: begin
        if (i_op_ready) begin
          op_valid_d = 1'b1;
          op_mode_d  = i_op_rdata;
        end
      end
      StIssue: begin
        op_valid_d = 1'b0;
        if (op_mode_q == 4'd0) begin
          ld_idx_d   = '0;
          in_valid_d = 1'b1;
        end
      end
      StLoad: begin
        if (in_accept) begin
          ld_idx_d = ld_idx_q + 1'b1;
          if (ld_idx_q == LdLast) in_valid_d = 1'b0;
        end
      end
      StNext: begin
        if (op_idx_q == OpLast) done_d = 1'b1;
        else                    op_idx_d = op_idx_q + 1'b1;
      end
      default: ;
    endcase

    // Checker runs in every state but IDLE so trailing beats after DONE still count
    if ((state_q != StIdle) && i_out_valid) begin
      out_cnt_d = out_cnt_q + 1'b1;
      if ((i_out_data != i_gd_rdata) && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end

    // A new run clears the counters, taking priority over a same-cycle beat
    if (start_ok) begin
      op_idx_d  = '0;
      out_cnt_d = '0;
      err_cnt_d = '0;
      done_d    = 1'b0;
    end
  end

  assign o_op_valid = op_valid_q;
  assign o_op_mode  = op_mode_q;
  assign o_in_valid = in_valid_q;
  assign o_in_data  = i_in_rdata;
  assign o_op_addr  = op_idx_q;
  assign o_in_addr  = ld_idx_q;
  assign o_gd_addr  = out_cnt_q;
  assign o_done     = done_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_out_cnt  = out_cnt_q;

endmodule

// File: tb/tb_core_stim_driver.sv
// Self-checking bench for core_stim_driver: ROM models, a small core model and
// directed runs with randomized data and flow control.
module tb_core_stim_driver;

  localparam int unsigned OP_NUM   = 2;
  localparam int unsigned LOAD_LEN = 2048;
  localparam int unsigned OP_AW    = 10;
  localparam int unsigned IN_AW    = 11;
  localparam int unsigned GD_AW    = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             o_op_valid;
  logic [3:0]       o_op_mode;
  logic             i_op_ready;
  logic             o_in_valid;
  logic [7:0]       o_in_data;
  logic             in_ready = 1'b1;
  logic             out_valid = 1'b0;
  logic [13:0]      out_data = '0;
  logic [OP_AW-1:0] o_op_addr;
  logic [3:0]       i_op_rdata;
  logic [IN_AW-1:0] o_in_addr;
  logic [7:0]       i_in_rdata;
  logic [GD_AW-1:0] o_gd_addr;
  logic [13:0]      i_gd_rdata;
  logic             o_done;
  logic [15:0]      o_err_cnt;
  logic [GD_AW-1:0] o_out_cnt;

  logic [3:0]  op_rom [0:(1<<OP_AW)-1];
  logic [7:0]  in_rom [0:(1<<IN_AW)-1];
  logic [13:0] gd_rom [0:(1<<GD_AW)-1];

  assign i_op_rdata = op_rom[o_op_addr];
  assign i_in_rdata = in_rom[o_in_addr];
  assign i_gd_rdata = gd_rom[o_gd_addr];

  int checks = 0;
  int errors = 0;
  int exp_out = 0;
  int exp_err = 0;

  logic       op_ready_en = 1'b1;
  logic       rnd_ready = 1'b0;
  logic       busy;
  logic [3:0] busy_mode;
  int         busy_cnt;

  logic [7:0] byte_q [$];
  logic [3:0] mode_q [$];

  core_stim_driver #(
    .OP_NUM  (OP_NUM),
    .LOAD_LEN(LOAD_LEN),
    .OP_AW   (OP_AW),
    .IN_AW   (IN_AW),
    .GD_AW   (GD_AW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .o_op_valid (o_op_valid),
    .o_op_mode  (o_op_mode),
    .i_op_ready (i_op_ready),
    .o_in_valid (o_in_valid),
    .o_in_data  (o_in_data),
    .i_in_ready (in_ready),
    .i_out_valid(out_valid),
    .i_out_data (out_data),
    .o_op_addr  (o_op_addr),
    .i_op_rdata (i_op_rdata),
    .o_in_addr  (o_in_addr),
    .i_in_rdata (i_in_rdata),
    .o_gd_addr  (o_gd_addr),
    .i_gd_rdata (i_gd_rdata),
    .o_done     (o_done),
    .o_err_cnt  (o_err_cnt),
    .o_out_cnt  (o_out_cnt)
  );

  always #5 clk = ~clk;

  // Core model: op_ready drops after an op and returns when the op completes
  assign i_op_ready = op_ready_en & ~busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      busy_mode <= 4'd0;
      busy_cnt  <= 0;
    end else if (o_op_valid) begin
      busy      <= 1'b1;
      busy_mode <= o_op_mode;
      busy_cnt  <= 0;
    end else if (busy) begin
      if (busy_mode == 4'd0) begin
        if (o_in_valid && in_ready) begin
          busy_cnt <= busy_cnt + 1;
          if (busy_cnt == int'(LOAD_LEN) - 1) busy <= 1'b0;
        end
      end else begin
        busy_cnt <= busy_cnt + 1;
        if (busy_cnt == 3) busy <= 1'b0;
      end
    end
  end

  // Byte-level flow control, changed away from the active edge
  always @(negedge clk) begin
    in_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Log accepted bytes and issued ops as the core sees them
  always @(posedge clk) begin
    if (rst_n) begin
      if (o_in_valid && in_ready) byte_q.push_back(o_in_data);
      if (o_op_valid) mode_q.push_back(o_op_mode);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input bit corrupt);
    @(negedge clk);
    out_valid = 1'b1;
    out_data  = gd_rom[exp_out % (1 << GD_AW)] ^ (corrupt ? 14'h0001 : 14'h0000);
    exp_out++;
    if (corrupt) exp_err++;
    @(negedge clk);
    out_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(o_done), 32'd1);
  endtask

  task automatic clear_logs();
    byte_q.delete();
    mode_q.delete();
  endtask

  // Reference: one op of each ROM entry in order, mode-0 ops stream ROM[0..LOAD_LEN-1]
  task automatic verify_run(input string tag);
    int bad = 0;
    logic [3:0] m0, m1;
    for (int i = 0; i < byte_q.size(); i++) begin
      if (i >= int'(LOAD_LEN) || byte_q[i] !== in_rom[i]) bad++;
    end
    check({tag, "_byte_count"}, 32'(byte_q.size()), 32'(LOAD_LEN));
    check({tag, "_byte_order"}, 32'(bad), 32'd0);
    m0 = (mode_q.size() > 0) ? mode_q[0] : 4'hF;
    m1 = (mode_q.size() > 1) ? mode_q[1] : 4'hF;
    check({tag, "_op_count"}, 32'(mode_q.size()), 32'(OP_NUM));
    check({tag, "_op0_mode"}, 32'(m0), 32'(op_rom[0]));
    check({tag, "_op1_mode"}, 32'(m1), 32'(op_rom[1]));
    check({tag, "_out_cnt"}, 32'(o_out_cnt), 32'(exp_out));
    check({tag, "_err_cnt"}, 32'(o_err_cnt), 32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi_cnt;
    for (int i = 0; i < (1 << OP_AW); i++) op_rom[i] = 4'($urandom_range(1, 15));
    for (int i = 0; i < (1 << IN_AW); i++) in_rom[i] = 8'($urandom);
    for (int i = 0; i < (1 << GD_AW); i++) gd_rom[i] = 14'($urandom);
    op_rom[0] = 4'd0;
    op_rom[1] = 4'd3;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_op_valid", 32'(o_op_valid), 32'd0);
    check("rst_in_valid", 32'(o_in_valid), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_op_mode", 32'(o_op_mode), 32'd0);
    check("rst_out_cnt", 32'(o_out_cnt), 32'd0);
    check("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    rst_n = 1'b1;

    // Run 1: always-ready core, five beats with beat 2 wrong
    clear_logs();
    pulse_start();
    @(negedge clk);
    check("r1_issue_valid", 32'(o_op_valid), 32'd1);
    check("r1_issue_mode", 32'(o_op_mode), 32'd0);
    @(negedge clk);
    check("r1_issue_width", 32'(o_op_valid), 32'd0);
    check("r1_first_in_valid", 32'(o_in_valid), 32'd1);
    check("r1_first_in_data", 32'(o_in_data), 32'(in_rom[0]));
    for (int b = 0; b < 5; b++) send_beat(b == 2);
    check("r1_beats_out_cnt", 32'(o_out_cnt), 32'd5);
    check("r1_beats_err_cnt", 32'(o_err_cnt), 32'd1);
    // Start while busy must be ignored
    pulse_start();
    @(negedge clk);
    check("r1_busy_start_op_addr", 32'(o_op_addr), 32'd0);
    check("r1_busy_start_out_cnt", 32'(o_out_cnt), 32'd5);
    check("r1_busy_start_in_valid", 32'(o_in_valid), 32'd1);
    wait_done("r1", 6000);
    verify_run("r1");
    // Trailing beats after DONE are still counted
    send_beat(1'b0);
    send_beat(1'b0);
    check("r1_trail_out_cnt", 32'(o_out_cnt), 32'd7);
    check("r1_trail_err_cnt", 32'(o_err_cnt), 32'd1);

    // Run 2: restart from DONE with random in_ready
    rnd_ready = 1'b1;
    clear_logs();
    exp_out = 0;
    exp_err = 0;
    pulse_start();
    check("r2_clr_out_cnt", 32'(o_out_cnt), 32'd0);
    check("r2_clr_err_cnt", 32'(o_err_cnt), 32'd0);
    check("r2_clr_done", 32'(o_done), 32'd0);
    repeat (20) @(negedge clk);
    send_beat(1'b1);
    send_beat(1'b0);
    send_beat(1'b1);
    wait_done("r2", 12000);
    verify_run("r2");

    // Run 3: op_ready held low for 100 cycles
    rnd_ready = 1'b0;
    op_ready_en = 1'b0;
    clear_logs();
    exp_out = 0;
    exp_err = 0;
    pulse_start();
    hi_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_op_valid) hi_cnt++;
    end
    check("r3_no_issue_while_low", 32'(hi_cnt), 32'd0);
    op_ready_en = 1'b1;
    @(negedge clk);
    check("r3_issue_after_ready", 32'(o_op_valid), 32'd1);
    @(negedge clk);
    check("r3_issue_width", 32'(o_op_valid), 32'd0);
    wait_done("r3", 6000);
    verify_run("r3");

    // Run 4: reset at load index 1000, then replay
    clear_logs();
    exp_out = 0;
    exp_err = 0;
    pulse_start();
    send_beat(1'b1);
    n = 0;
    while (!(o_in_valid && o_in_addr == 11'd1000) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("r4_reached_1000", 32'(o_in_addr), 32'd1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("r4_rst_in_valid", 32'(o_in_valid), 32'd0);
    check("r4_rst_op_valid", 32'(o_op_valid), 32'd0);
    check("r4_rst_out_cnt", 32'(o_out_cnt), 32'd0);
    check("r4_rst_err_cnt", 32'(o_err_cnt), 32'd0);
    check("r4_rst_in_addr", 32'(o_in_addr), 32'd0);
    check("r4_rst_op_addr", 32'(o_op_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("r4_idle_no_in_valid", 32'(o_in_valid), 32'd0);
    check("r4_idle_no_done", 32'(o_done), 32'd0);
    clear_logs();
    exp_out = 0;
    exp_err = 0;
    pulse_start();
    wait_done("r4", 6000);
    verify_run("r4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_stim_driver.md
Name: core_stim_driver

Overview:
- Synthesizable host-side initiator for the core's op/in/out protocol. Drives the other end of the core's interface.
- Fetches op codes from an op ROM and issues each one with an op_valid/op_ready handshake. For load ops (mode 0) it streams LOAD_LEN bytes from a data ROM under in_valid/in_ready flow control.
- In parallel it checks every out_valid beat against a golden ROM.
- Used for on-chip self-test and FPGA bring-up of the core.

Parameters:
OP_NUM, 41, number of ops to issue per run
LOAD_LEN, 2048, bytes streamed per mode-0 op
OP_AW, 10, op ROM address width
IN_AW, 11, data ROM address width
GD_AW, 12, golden ROM address width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse that starts a run; ignored unless the state is IDLE or DONE
o_op_valid  out  1  op strobe to core, one cycle per op
o_op_mode  out  4  op code to core, valid while o_op_valid=1
i_op_ready  in  1  core can accept an op
o_in_valid  out  1  input byte valid
o_in_data  out  8  input byte, passthrough of i_in_rdata
i_in_ready  in  1  core accepts the byte this cycle
i_out_valid  in  1  core output beat valid
i_out_data  in  14  core output beat
o_op_addr  out  OP_AW  op ROM address (op index)
i_op_rdata  in  4  op ROM data, combinational read
o_in_addr  out  IN_AW  data ROM address (load index)
i_in_rdata  in  8  data ROM data, combinational read
o_gd_addr  out  GD_AW  golden ROM address (output beat count)
i_gd_rdata  in  14  golden ROM data, combinational read
o_done  out  1  run complete, held until next start
o_err_cnt  out  16  mismatch count
o_out_cnt  out  GD_AW  number of output beats received

Behaviour:
- Reset (async, any state, including mid-load):
  - state=IDLE.
  - o_op_valid, o_in_valid, o_done all 0.
  - o_op_mode, op index, load index, o_out_cnt, o_err_cnt all 0.
- FSM states: IDLE, WAIT_RDY, ISSUE, LOAD, NEXT, DONE.
- IDLE/DONE + i_start=1:
  - clear op index, o_out_cnt, o_err_cnt and o_done.
  - go to WAIT_RDY.
- WAIT_RDY + i_op_ready=1:
  - next edge registers o_op_valid=1 and o_op_mode=i_op_rdata.
  - go to ISSUE.
- ISSUE: lasts exactly one cycle with o_op_valid=1; the next edge clears o_op_valid.
  - If o_op_mode=0: clear load index, go to LOAD.
  - Otherwise: go to NEXT.
- Core contract: i_op_ready is low from the cycle after op_valid until the op completes. The driver never issues two ops without seeing i_op_ready high in WAIT_RDY.
- LOAD:
  - o_in_valid=1; o_in_addr=load index; o_in_data=i_in_rdata.
  - Each cycle with o_in_valid & i_in_ready: load index +1.
  - On acceptance of byte LOAD_LEN-1: o_in_valid drops at the next edge and state goes to NEXT.
  - i_in_ready low: hold data, index and valid. No byte is skipped or duplicated.
- NEXT:
  - If op index = OP_NUM-1: go to DONE, o_done=1.
  - Otherwise: op index +1, go to WAIT_RDY.
- Checker: active in every state except IDLE.
  - Each cycle with i_out_valid=1: compare i_out_data against i_gd_rdata at o_gd_addr=o_out_cnt.
  - Mismatch: o_err_cnt +1, saturating at 16'hFFFF.
  - o_out_cnt +1 every beat, wrapping at 2^GD_AW.
  - In DONE the checker keeps counting, so trailing core outputs are checked.
- Simultaneous events:
  - i_out_valid during ISSUE/LOAD is checked normally.
  - i_start while busy is ignored.
  - Reset asserted mid-load drops o_in_valid asynchronously.
- Latency: op issue is 1 cycle after i_op_ready is sampled high in WAIT_RDY. The first load byte is presented 1 cycle after ISSUE.
- All outputs except o_in_data are registered.

Test Plan:
- Reset, i_start, OP_NUM=2, ops {0,3}, core model always ready:
  - exactly 2048 accepted bytes, equal to ROM[0..2047] in order.
  - then one op_valid with mode 3.
  - o_done=1 after NEXT.
- Same run with i_in_ready toggling on a pseudo-random pattern (about 50% duty):
  - byte sequence still ROM[0..2047], no duplicates or gaps.
  - total handshakes 2048.
- i_op_ready held low for 100 cycles after start:
  - o_op_valid stays 0.
  - on the cycle i_op_ready rises, o_op_valid=1 on the following cycle, width 1.
- Core model emits 5 beats; beat 2 differs from golden:
  - o_out_cnt=5, o_err_cnt=1.
  - two beats arriving after o_done are also counted.
- Assert i_rst_n low at load index 1000:
  - o_in_valid=0 immediately; all counters 0; state IDLE.
  - a new i_start replays from op 0, byte 0.
- Pulse i_start mid-run:
  - no effect on op index or counters.
  - pulse i_start in DONE: counters clear and the run repeats.
